// File: rtl/md5_pkg.sv
// Shared MD5 constants, state encoding and per-step helper functions used by
// the md5_core compression engine and its combinational step.
package md5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] S_TAB [0:63] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] f_sel(input logic [1:0] r, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        case (r)
            2'd0:    return (b & c) | (~b & d);
            2'd1:    return (d & b) | (~d & c);
            2'd2:    return b ^ c ^ d;
            default: return c ^ (b | ~d);
        endcase
    endfunction

    // Message word index; only the low four bits of j matter modulo 16.
    function automatic logic [3:0] g_idx(input logic [5:0] j);
        logic [3:0] jl;
        jl = j[3:0];
        case (j[5:4])
            2'd0:    return jl;
            2'd1:    return jl * 4'd5 + 4'd1;
            2'd2:    return jl * 4'd3 + 4'd5;
            default: return jl * 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/md5_core_if.sv
// Block input handshake and digest output bundle for md5_core.
interface md5_core_if;
    logic         in_valid;
    logic         in_ready;
    logic         first_block;
    logic [511:0] block_in;
    logic [127:0] digest;
    logic         digest_valid;
    logic         busy;

    modport master (
        output in_valid, first_block, block_in,
        input  in_ready, digest, digest_valid, busy
    );

    modport slave (
        input  in_valid, first_block, block_in,
        output in_ready, digest, digest_valid, busy
    );
endinterface

// File: rtl/md5_step.sv
// One combinational MD5 step: mixes A..D with message word M[g(j)] and K[j].
module md5_step
    import md5_pkg::*;
(
    input  logic [31:0]  i_a,
    input  logic [31:0]  i_b,
    input  logic [31:0]  i_c,
    input  logic [31:0]  i_d,
    input  logic [5:0]   i_j,
    input  logic [511:0] i_m,
    output logic [31:0]  o_a,
    output logic [31:0]  o_b,
    output logic [31:0]  o_c,
    output logic [31:0]  o_d
);

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    logic [31:0] w_f;
    logic [31:0] w_m;
    logic [31:0] w_sum;
    logic [3:0]  w_g;

    always_comb begin
        w_f   = f_sel(i_j[5:4], i_b, i_c, i_d);
        w_g   = g_idx(i_j);
        w_m   = i_m[{w_g, 5'd0} +: 32];
        w_sum = i_a + w_f + K_TAB[i_j] + w_m;
        o_a   = i_d;
        o_b   = i_b + rotl32(w_sum, S_TAB[i_j]);
        o_c   = i_b;
        o_d   = i_c;
    end

endmodule

// File: rtl/md5_core.sv
// MD5 compression engine: accepts 512-bit padded blocks, runs UNROLL steps per
// clock and chains the hash across blocks until first_block restarts it.
module md5_core
    import md5_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic       clk,
    input  logic       rst,
    md5_core_if.slave  bus
);

    localparam int         NCYC   = 64 / UNROLL;
    localparam logic [5:0] J_STEP = 6'(UNROLL);
    localparam logic [5:0] J_LAST = 6'((NCYC - 1) * UNROLL);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("md5_core: UNROLL must be 1, 2, 4, 8 or 16");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic [5:0]          r_j;
    logic [511:0]        r_msg;
    logic [31:0]         r_a, r_b, r_c, r_d;
    logic [31:0]         r_h0, r_h1, r_h2, r_h3;
    logic [127:0]        r_digest;
    logic                r_dvalid;
    logic [UNROLL:0][31:0] w_a, w_b, w_c, w_d;

    assign w_a[0] = r_a;
    assign w_b[0] = r_b;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        md5_step u_step (
            .i_a (w_a[k]),
            .i_b (w_b[k]),
            .i_c (w_c[k]),
            .i_d (w_d[k]),
            .i_j (r_j + 6'(k)),
            .i_m (r_msg),
            .o_a (w_a[k+1]),
            .o_b (w_b[k+1]),
            .o_c (w_c[k+1]),
            .o_d (w_d[k+1])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (r_j == J_LAST) begin
                    w_state_nxt = FINAL;
                end
            end
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready     = (r_state == IDLE);
    assign bus.busy         = (r_state != IDLE);
    assign bus.digest       = r_digest;
    assign bus.digest_valid = r_dvalid;

    // A new message also resets the chain so FINAL adds onto IV, not the old hash.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_j      <= '0;
            r_dvalid <= 1'b0;
            r_digest <= '0;
            r_h0     <= IV0;
            r_h1     <= IV1;
            r_h2     <= IV2;
            r_h3     <= IV3;
        end else begin
            r_state  <= w_state_nxt;
            r_dvalid <= 1'b0;
            if (w_accept) begin
                r_j <= '0;
                if (bus.first_block) begin
                    r_h0 <= IV0;
                    r_h1 <= IV1;
                    r_h2 <= IV2;
                    r_h3 <= IV3;
                end
            end else if (r_state == ROUND) begin
                r_j <= r_j + J_STEP;
            end
            if (r_state == FINAL) begin
                r_h0     <= r_h0 + r_a;
                r_h1     <= r_h1 + r_b;
                r_h2     <= r_h2 + r_c;
                r_h3     <= r_h3 + r_d;
                r_digest <= {r_h3 + r_d, r_h2 + r_c, r_h1 + r_b, r_h0 + r_a};
                r_dvalid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_msg <= bus.block_in;
            if (bus.first_block) begin
                r_a <= IV0;
                r_b <= IV1;
                r_c <= IV2;
                r_d <= IV3;
            end else begin
                r_a <= r_h0;
                r_b <= r_h1;
                r_c <= r_h2;
                r_d <= r_h3;
            end
        end else if (r_state == ROUND) begin
            r_a <= w_a[UNROLL];
            r_b <= w_b[UNROLL];
            r_c <= w_c[UNROLL];
            r_d <= w_d[UNROLL];
        end
    end

endmodule

// File: tb/tb_md5_core.sv
// Bench for md5_core at UNROLL = 1, 2, 4 and 16 driven by one shared stimulus
// stream, each instance compared every cycle against a software MD5 model.
module tb_md5_core;

    localparam logic [127:0] IV_H     = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] D_EMPTY  = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] D_ABC    = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

    logic         clk = 1'b0;
    logic         rst;
    logic         tb_valid;
    logic         tb_first;
    logic [511:0] tb_blk;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] kconst(input int i);
        real x;
        x = $sin(real'(i + 1));
        if (x < 0.0) x = -x;
        return 32'(longint'($floor(x * 4294967296.0)));
    endfunction

    // Plain software MD5 compression of one block onto chaining value h.
    function automatic logic [127:0] md5_ref(input logic [127:0] h, input logic [511:0] blk);
        int          sh4 [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        logic [31:0] a, b, c, d, f, t;
        int          g, sh;
        a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;              end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            sh = sh4[(i / 16) * 4 + (i % 4)];
            t  = a + f + kconst(i) + blk[32 * g +: 32];
            t  = (t << sh) | (t >> (32 - sh));
            a  = d; d = c; c = b; b = b + t;
        end
        return {h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_u
        localparam int UL = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 16;
        localparam int NC = 64 / UL;

        md5_core_if bus ();
        assign bus.in_valid    = tb_valid;
        assign bus.first_block = tb_first;
        assign bus.block_in    = tb_blk;

        md5_core #(.UNROLL(UL)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        int           cnt = 0;
        bit           armed = 1'b0;
        logic         exp_v;
        logic [127:0] exp_d;
        logic [127:0] pend;

        // cnt counts edges left until the digest appears; zero means ready.
        always @(posedge clk) begin
            if (rst) begin
                cnt   <= 0;
                exp_v <= 1'b0;
                exp_d <= '0;
                pend  <= IV_H;
                armed <= 1'b1;
            end else begin
                exp_v <= 1'b0;
                if (cnt > 1) begin
                    cnt <= cnt - 1;
                end else if (cnt == 1) begin
                    cnt   <= 0;
                    exp_v <= 1'b1;
                    exp_d <= pend;
                end else if (tb_valid) begin
                    pend <= md5_ref(tb_first ? IV_H : pend, tb_blk);
                    cnt  <= NC + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                chk($sformatf("u%0d in_ready", UL), {127'd0, bus.in_ready}, {127'd0, cnt == 0});
                chk($sformatf("u%0d busy", UL), {127'd0, bus.busy}, {127'd0, cnt != 0});
                chk($sformatf("u%0d digest_valid", UL), {127'd0, bus.digest_valid}, {127'd0, exp_v});
                chk($sformatf("u%0d digest", UL), bus.digest, exp_d);
            end
        end
    end

    function automatic bit all_idle();
        return g_u[0].cnt == 0 && g_u[1].cnt == 0 && g_u[2].cnt == 0 && g_u[3].cnt == 0;
    endfunction

    task automatic wait_idle();
        for (int n = 0; n < 300 && !all_idle(); n++) begin
            @(posedge clk);
            #1;
        end
        if (!all_idle()) begin
            errors++;
            checks++;
            $display("FAIL wait_idle: got busy expected idle within 300 cycles");
        end
    endtask

    task automatic send(input logic first, input logic [511:0] blk);
        wait_idle();
        tb_valid = 1'b1;
        tb_first = first;
        tb_blk   = blk;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [127:0] exp);
        chk({nm, " u1"},  g_u[0].bus.digest, exp);
        chk({nm, " u2"},  g_u[1].bus.digest, exp);
        chk({nm, " u4"},  g_u[2].bus.digest, exp);
        chk({nm, " u16"}, g_u[3].bus.digest, exp);
    endtask

    logic [511:0] blk_empty, blk_abc, blk_a64, blk_pad;

    initial begin
        blk_empty = '0;
        blk_empty[31:0] = 32'h00000080;
        blk_abc = '0;
        blk_abc[31:0] = 32'h80636261;
        blk_abc[14*32 +: 32] = 32'h00000018;
        blk_a64 = {16{32'h61616161}};
        blk_pad = '0;
        blk_pad[31:0] = 32'h00000080;
        blk_pad[14*32 +: 32] = 32'h00000200;

        rst = 1'b1; tb_valid = 1'b0; tb_first = 1'b0; tb_blk = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("model empty", md5_ref(IV_H, blk_empty), D_EMPTY);
        chk("model abc", md5_ref(IV_H, blk_abc), D_ABC);
        lit("reset digest", 128'd0);

        send(1'b1, blk_empty);
        wait_idle();
        lit("empty", D_EMPTY);

        send(1'b1, blk_abc);
        wait_idle();
        lit("abc", D_ABC);

        send(1'b1, blk_a64);
        send(1'b0, blk_pad);
        wait_idle();
        lit("a x64", md5_ref(md5_ref(IV_H, blk_a64), blk_pad));

        send(1'b1, blk_abc);
        wait_idle();
        lit("abc restart", D_ABC);

        // Held in_valid: each instance re-accepts in its digest_valid cycle.
        tb_valid = 1'b1; tb_first = 1'b1; tb_blk = blk_abc;
        repeat (70) @(posedge clk);
        #1 tb_valid = 1'b0;
        wait_idle();
        lit("back-to-back", D_ABC);

        send(1'b0, blk_abc);
        @(posedge clk); #1 tb_valid = 1'b1; tb_first = 1'b1; tb_blk = blk_empty;
        @(posedge clk); #1 tb_valid = 1'b0;
        @(posedge clk); #1 tb_valid = 1'b1;
        @(posedge clk); #1 tb_valid = 1'b0;
        wait_idle();
        lit("chained abc", md5_ref(D_ABC, blk_abc));

        send(1'b1, blk_a64);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        lit("after reset", 128'd0);
        repeat (70) @(posedge clk);
        #1;
        lit("no late digest", 128'd0);

        send(1'b0, blk_empty);
        wait_idle();
        lit("empty after reset", D_EMPTY);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md5_core.md
Name: md5_core

Overview:
- Self-contained MD5 compression engine with its own controller, step counter, message-schedule indexing and chaining registers.
- Supersedes the split datapath-plus-external-controller arrangement.
- Parametrised by the number of MD5 steps evaluated per clock.
- Supports multi-block messages by chaining the hash across blocks. Uses a valid/ready input handshake and a digest-valid output pulse.

Parameters:
- UNROLL, 1, MD5 steps per clock; legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NCYC, 64/UNROLL, derived (localparam), number of round cycles per block.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  a block is presented.
- in_ready  out  1  core can accept a block.
- first_block  in  1  qualified by in_valid; 1 = start a new message (chain = IV).
- block_in  in  512  padded block; M[i] = block_in[32i+31:32i], each word already little-endian.
- digest  out  128  chaining value; H0 at [31:0], H1 [63:32], H2 [95:64], H3 [127:96].
- digest_valid  out  1  single-cycle pulse when a block finishes.
- busy  out  1  high in ROUND and FINAL.

Behaviour:
- Reset values:
  - state = IDLE, in_ready = 1, busy = 0, digest_valid = 0, digest = 0.
  - Chaining H0..H3 = IV: 67452301, efcdab89, 98badcfe, 10325476.
  - j = 0.
- States IDLE -> ROUND -> FINAL -> IDLE.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - latch block_in into a message register;
  - load A..D from IV if first_block, otherwise from H0..H3;
  - set j = 0 and go to ROUND.
- ROUND: each clock applies UNROLL consecutive steps j..j+UNROLL-1, then j += UNROLL. After NCYC clocks (j wraps to 0), go to FINAL.
- Step j, with r = j/16:
  - F by r:
    - r = 0: (B&C)|(~B&D)
    - r = 1: (D&B)|(~D&C)
    - r = 2: B^C^D
    - r = 3: C^(B|~D)
  - Message index g by r (mod 16): j, 5j+1, 3j+5, 7j.
  - Update: newB = B + rotl32(A+F+K[j]+M[g], S[j]); then A<=D, D<=C, C<=B, B<=newB.
  - All additions are modulo 2^32 with carries discarded.
- FINAL: H0 += A, H1 += B, H2 += C, H3 += D (mod 2^32). Drive digest from the updated H, pulse digest_valid for exactly 1 cycle, return to IDLE.
- Latency: digest_valid is high in the cycle following NCYC+1 clock edges after the accepting edge, i.e. 65 edges for UNROLL=1 and 5 edges for UNROLL=16.
- in_ready is 0 throughout ROUND and FINAL; in_valid there is ignored and does not need to be held stable.
- A new block may be accepted in the same cycle digest_valid is high.
- digest holds its value until the next FINAL; it does not clear on accept.
- first_block = 0 on the first block after reset uses the reset H (= IV).
- Reset mid-operation: abort immediately and restore every reset value above. No digest_valid for the aborted block.

Decomposition:
- md5_pkg holds:
  - K[0:63] and S[0:63] constant tables;
  - IV constants;
  - state enum {IDLE, ROUND, FINAL};
  - functions f_sel(r, B, C, D) and g_idx(j).
- Sub-module md5_step: one combinational MD5 step.
  - Inputs: A, B, C, D, j, message vector.
  - Outputs: next A, B, C, D.
- md5_core chains UNROLL instances of md5_step via generate; each instance gets j+k.

Test Plan:
- Empty message: first_block = 1, M[0] = 00000080, others 0; UNROLL=1 -> after 65 edges digest_valid pulses and H0..H3 = d98c1dd4, 04b2008f, 980980e9, 7e42f8ec (d41d8cd98f00b204e9800998ecf8427e).
- "abc": M[0] = 80636261, M[14] = 00000018, others 0 -> H0..H3 = 98500190, b04fd23c, 7d3f96d6, 727fe128. Repeat for UNROLL = 2, 4 and 16; identical digest, latency NCYC+1.
- Two-block message: a 64-byte string of "a" (M[i] = 61616161) with first_block = 1, then a padding block (M[0] = 00000080, M[14] = 00000200) with first_block = 0 -> digest equals the reference-model MD5 of "a"x64. Then the "abc" block with first_block = 1 -> "abc" digest, proving the chain restarts.
- Back-to-back: in_valid held high across two blocks -> second accept happens in the digest_valid cycle; in_valid pulses during ROUND are ignored (in_ready = 0, no extra digest).
- Reset at j = 30 -> next cycle state = IDLE, in_ready = 1, digest = 0, no digest_valid. A following empty-message block gives the correct digest.
